axi_slave_r: RTL and testbench

AXI4 read-slave responder that sits directly downstream of axi_master_r. It accepts one AR request at a time and returns ARLEN+1 R beats with RLAST. Read data comes from a deterministic address-derived pattern (no RAM), so the master's address sequencing can be checked beat by beat. It is used as the bus endpoint in master-side benches and as a stub target in integration.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_burst_addr_gen.sv | 32 +++
 rtl/axi_slave_r.sv | 193 +++++++++++++++++++
 tb/tb_axi_slave_r.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-slave FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BEAT
    } rd_state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared by read and write slaves.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WD = 32
) (
    input  logic [ADDR_WD-1:0] cur,
    input  logic [ADDR_WD-1:0] start,
    input  logic [2:0]         size,
    input  logic [7:0]         len,
    input  logic [1:0]         burst,
    output logic [ADDR_WD-1:0] next
);

    logic [ADDR_WD-1:0] inc;
    logic [ADDR_WD-1:0] align;
    logic [ADDR_WD-1:0] wrap_mask;

    always_comb begin
        inc       = ADDR_WD'(1) << size;
        align     = cur & ~(inc - ADDR_WD'(1));
        wrap_mask = ((ADDR_WD'(len) + ADDR_WD'(1)) << size) - ADDR_WD'(1);
        case (burst)
            BURST_FIXED: next = cur;
            // First beat may be unaligned; every later beat is aligned to the size.
            BURST_INCR:  next = align + inc;
            BURST_WRAP:  next = (start & ~wrap_mask) + ((cur + inc) & wrap_mask);
            default:     next = cur;
        endcase
    end

endmodule

// File: rtl/axi_slave_r.sv
// AXI4 read-slave responder returning an address-derived byte pattern, one burst at a time.
module axi_slave_r
    import axi_pkg::*;
#(
    parameter int ADDR_WD     = 32,
    parameter int DATA_WD     = 32,
    parameter int MEM_ADDR_WD = 16,
    parameter int RD_LATENCY  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               S_AXI_ARVALID,
    input  logic [1:0]         S_AXI_ARBURST,
    input  logic [2:0]         S_AXI_ARSIZE,
    input  logic [ADDR_WD-1:0] S_AXI_ARADDR,
    input  logic [7:0]         S_AXI_ARLEN,
    output logic               S_AXI_ARREADY,
    output logic               S_AXI_RVALID,
    output logic               S_AXI_RLAST,
    output logic [DATA_WD-1:0] S_AXI_RDATA,
    output logic [1:0]         S_AXI_RRESP,
    input  logic               S_AXI_RREADY
);

    localparam int NBYTES   = DATA_WD / 8;
    localparam int BYTE_LSB = $clog2(NBYTES);
    localparam int WAIT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    rd_state_t          state_q, state_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic               rlast_q, rlast_d;
    logic [DATA_WD-1:0] rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [1:0]         burst_q, burst_d;
    logic [2:0]         size_q, size_d;
    logic [ADDR_WD-1:0] start_q, start_d;
    logic [ADDR_WD-1:0] cur_q, cur_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               berr_q, berr_d;

    logic [ADDR_WD-1:0] nxt_addr;
    logic [ADDR_WD-1:0] ar_inc;
    logic               ar_err;
    logic [ADDR_WD-1:0] beat_addr;
    logic [7:0]         beat_idx;
    logic               beat_err;

    function automatic logic [DATA_WD-1:0] beat_data(input logic [7:0] a_lo);
        logic [DATA_WD-1:0] d;
        logic [7:0]         w;
        w = a_lo & ~8'((1 << BYTE_LSB) - 1);
        d = '0;
        for (int i = 0; i < NBYTES; i++) begin
            d[i*8 +: 8] = w + 8'(i);
        end
        return d;
    endfunction

    function automatic logic in_range(input logic [ADDR_WD-1:0] a);
        return (a >> MEM_ADDR_WD) == '0;
    endfunction

    axi_burst_addr_gen #(
        .ADDR_WD(ADDR_WD)
    ) u_addr_gen (
        .cur  (cur_q),
        .start(start_q),
        .size (size_q),
        .len  (len_q),
        .burst(burst_q),
        .next (nxt_addr)
    );

    // Whole-burst error conditions are decided once, from the AR channel.
    always_comb begin
        ar_inc = ADDR_WD'(1) << S_AXI_ARSIZE;
        ar_err = (32'(S_AXI_ARSIZE) > BYTE_LSB)
              || (S_AXI_ARBURST == 2'b11)
              || ((S_AXI_ARBURST == BURST_WRAP) && !wrap_len_ok(S_AXI_ARLEN))
              || ((S_AXI_ARBURST == BURST_WRAP) && ((S_AXI_ARADDR & (ar_inc - ADDR_WD'(1))) != '0));
    end

    // The first beat presents the latched start address; later beats the generated one.
    always_comb begin
        beat_addr = rvalid_q ? nxt_addr : cur_q;
        beat_idx  = rvalid_q ? (beat_cnt_q + 8'd1) : 8'd0;
        beat_err  = berr_q || !in_range(beat_addr);
    end

    always_comb begin
        state_d    = state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        burst_d    = burst_q;
        size_d     = size_q;
        start_d    = start_q;
        cur_d      = cur_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        berr_d     = berr_q;

        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (S_AXI_ARVALID && arready_q) begin
                    arready_d  = 1'b0;
                    burst_d    = S_AXI_ARBURST;
                    size_d     = S_AXI_ARSIZE;
                    start_d    = S_AXI_ARADDR;
                    cur_d      = S_AXI_ARADDR;
                    len_d      = S_AXI_ARLEN;
                    berr_d     = ar_err;
                    beat_cnt_d = '0;
                    wait_cnt_d = WAIT_W'(RD_LATENCY - 1);
                    state_d    = (RD_LATENCY > 1) ? WAIT : BEAT;
                end
            end
            WAIT: begin
                // Leaving one cycle early lets BEAT register the first beat on time.
                wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                if (wait_cnt_q <= WAIT_W'(1)) begin
                    state_d = BEAT;
                end
            end
            BEAT: begin
                if (rvalid_q && S_AXI_RREADY && rlast_q) begin
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    arready_d = 1'b1;
                    state_d   = IDLE;
                end else if (!rvalid_q || S_AXI_RREADY) begin
                    rvalid_d   = 1'b1;
                    cur_d      = beat_addr;
                    beat_cnt_d = beat_idx;
                    rlast_d    = (beat_idx == len_q);
                    rresp_d    = beat_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d    = beat_err ? '0 : beat_data(beat_addr[7:0]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            burst_q    <= BURST_FIXED;
            size_q     <= '0;
            start_q    <= '0;
            cur_q      <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            burst_q    <= burst_d;
            size_q     <= size_d;
            start_q    <= start_d;
            cur_q      <= cur_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            berr_q     <= berr_d;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_slave_r.sv
// Directed bench for axi_slave_r: table of bursts plus stall and mid-burst reset sequences.
module tb_axi_slave_r;

    logic        clk;
    logic        rst_n;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arready;
    logic        rvalid;
    logic        rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    int n_vec = 0;
    int n_mis = 0;

    axi_slave_r #(
        .ADDR_WD    (32),
        .DATA_WD    (32),
        .MEM_ADDR_WD(16),
        .RD_LATENCY (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARBURST(arburst),
        .S_AXI_ARSIZE (arsize),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARLEN  (arlen),
        .S_AXI_ARREADY(arready),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RLAST  (rlast),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RREADY (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       burst;
        logic [2:0]       size;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [3:0][31:0] d;
        logic [3:0][1:0]  r;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] burst, input logic [2:0] size,
                                input logic [31:0] addr, input logic [7:0] len,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [1:0] r0, input logic [1:0] r1,
                                input logic [1:0] r2, input logic [1:0] r3);
        vec_t v;
        v.burst = burst; v.size = size; v.addr = addr; v.len = len;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_ar(input vec_t v, input string tag);
        int w;
        w = 0;
        while (!arready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!arready) chk({tag, " arready timeout"}, 64'(arready), 64'd1);
        arvalid = 1'b1;
        arburst = v.burst;
        arsize  = v.size;
        araddr  = v.addr;
        arlen   = v.len;
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    // Collect and check every beat of a burst with RREADY held high.
    task automatic run_burst(input vec_t v, input string tag);
        int w;
        do_ar(v, tag);
        for (int k = 0; k <= int'(v.len); k++) begin
            w = 0;
            while (!rvalid && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("%s b%0d wait", tag, k), 64'(w), (k == 0) ? 64'd1 : 64'd0);
            if (!rvalid) break;
            chk($sformatf("%s b%0d rdata", tag, k), 64'(rdata), 64'(v.d[k]));
            chk($sformatf("%s b%0d rresp", tag, k), 64'(rresp), 64'(v.r[k]));
            chk($sformatf("%s b%0d rlast", tag, k), 64'(rlast), (k == int'(v.len)) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        chk({tag, " end rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, " end arready"}, 64'(arready), 64'd1);
    endtask

    vec_t tbl[11];
    vec_t v;
    logic rr_pat[5];
    logic exp_last[5];
    int   w;

    initial begin
        tbl[0]  = mk(2'b01, 3'd2, 32'h0000_0000, 8'd3, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[1]  = mk(2'b10, 3'd2, 32'h0000_0038, 8'd3, 32'h3B3A3938, 32'h3F3E3D3C, 32'h33323130, 32'h37363534, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[2]  = mk(2'b01, 3'd2, 32'h0000_FFF8, 8'd3, 32'hFBFAF9F8, 32'hFFFEFDFC, 32'h0, 32'h0, 2'b00, 2'b00, 2'b10, 2'b10);
        tbl[3]  = mk(2'b11, 3'd2, 32'h0000_0000, 8'd1, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b00, 2'b00);
        tbl[4]  = mk(2'b10, 3'd2, 32'h0000_0000, 8'd2, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b10, 2'b00);
        tbl[5]  = mk(2'b01, 3'd0, 32'h0000_0005, 8'd2, 32'h07060504, 32'h07060504, 32'h07060504, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[6]  = mk(2'b01, 3'd2, 32'h0000_0006, 8'd1, 32'h07060504, 32'h0B0A0908, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[7]  = mk(2'b01, 3'd3, 32'h0000_0000, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 2'b00, 2'b00, 2'b00);
        tbl[8]  = mk(2'b10, 3'd2, 32'h0000_0002, 8'd1, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b00, 2'b00);
        tbl[9]  = mk(2'b00, 3'd2, 32'h0000_0010, 8'd2, 32'h13121110, 32'h13121110, 32'h13121110, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[10] = mk(2'b10, 3'd1, 32'h0000_0006, 8'd1, 32'h07060504, 32'h07060504, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);

        rst_n   = 1'b1;
        arvalid = 1'b0;
        arburst = 2'b00;
        arsize  = 3'd0;
        araddr  = 32'h0;
        arlen   = 8'd0;
        rready  = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset arready", 64'(arready), 64'd0);
        chk("reset rvalid", 64'(rvalid), 64'd0);
        chk("reset rlast", 64'(rlast), 64'd0);
        chk("reset rdata", 64'(rdata), 64'd0);
        chk("reset rresp", 64'(rresp), 64'd0);
        rst_n = 1'b1;
        chk("release arready", 64'(arready), 64'd0);
        @(negedge clk);
        chk("first edge arready", 64'(arready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            run_burst(tbl[i], $sformatf("vec%0d", i));
        end

        // FIXED burst with RREADY pattern 1,0,0,1,1: the middle beat is stalled twice.
        rr_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        v = mk(2'b00, 3'd2, 32'h0000_0010, 8'd2, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
        do_ar(v, "stall");
        w = 0;
        while (!rvalid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("stall first wait", 64'(w), 64'd1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall c%0d rvalid", c), 64'(rvalid), 64'd1);
            chk($sformatf("stall c%0d rdata", c), 64'(rdata), 64'h13121110);
            chk($sformatf("stall c%0d rlast", c), 64'(rlast), 64'(exp_last[c]));
            rready = rr_pat[c];
            @(negedge clk);
        end
        rready = 1'b1;
        chk("stall end rvalid", 64'(rvalid), 64'd0);
        chk("stall end arready", 64'(arready), 64'd1);

        // Reset while beat 2 of an 8-beat burst is on the bus.
        v = mk(2'b01, 3'd2, 32'h0000_0000, 8'd7, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
        do_ar(v, "rstburst");
        w = 0;
        while (!rvalid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rstburst b0 rdata", 64'(rdata), 64'h03020100);
        @(negedge clk);
        chk("rstburst b1 rdata", 64'(rdata), 64'h07060504);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst rvalid", 64'(rvalid), 64'd0);
        chk("async rst rlast", 64'(rlast), 64'd0);
        chk("async rst rdata", 64'(rdata), 64'd0);
        chk("async rst arready", 64'(arready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = mk(2'b01, 3'd2, 32'h0000_0040, 8'd0, 32'h43424140, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
        run_burst(v, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
